// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_stage : PC, instruction fetch and IF/ID register with boot hold-off    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module if_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 2,
   parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   output logic [31:0] ID_inst,
   output logic [31:0] ID_pc4,
   output logic        ID_valid,
   output logic [15:0] stall_count
);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] C_PC_RST     = RESET_PC & C_ALIGN_MASK;
   localparam logic [3:0]  C_BOOT_LAST  = 4'(BOOT_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  boot_cnt_q;
   logic [31:0] pc_q;
   logic [31:0] id_inst_q;
   logic [31:0] id_pc4_q;
   logic        id_valid_q;
   logic [15:0] stall_cnt_q;

   logic [31:0] pc_plus4_d;
   logic [31:0] redirect_pc_d;

   assign pc_plus4_d    = pc_q + 32'd4;
   assign redirect_pc_d = redirect_pc & C_ALIGN_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= 4'd0;
         pc_q        <= C_PC_RST;
         id_inst_q   <= NOP_INST;
         id_pc4_q    <= 32'd0;
         id_valid_q  <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               boot_cnt_q <= boot_cnt_q + 4'd1;
               if (boot_cnt_q == C_BOOT_LAST) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Redirect beats stall: the ID occupant is wrong-path either way.
               if (redirect_en) begin
                  pc_q       <= redirect_pc_d;
                  id_inst_q  <= NOP_INST;
                  id_pc4_q   <= 32'd0;
                  id_valid_q <= 1'b0;
               end else if (stall) begin
                  if (stall_cnt_q != 16'hFFFF) begin
                     stall_cnt_q <= stall_cnt_q + 16'd1;
                  end
               end else begin
                  id_inst_q  <= inst_data;
                  id_pc4_q   <= pc_plus4_d;
                  id_valid_q <= 1'b1;
                  pc_q       <= pc_plus4_d;
               end
            end
            default: state_q <= ST_BOOT;
         endcase
      end
   end

   assign inst_addr   = pc_q;
   assign ID_inst     = id_inst_q;
   assign ID_pc4      = id_pc4_q;
   assign ID_valid    = id_valid_q;
   assign stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_stage : randomized + directed self-checking bench for if_stage      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall = 1'b0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic [31:0] ID_inst;
   logic [31:0] ID_pc4;
   logic        ID_valid;
   logic [15:0] stall_count;

   int n_total = 0;
   int n_pass  = 0;
   bit cmp_en  = 1'b0;

   // Reference model state, expressed as plain values
   int          m_boot_left;
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   logic        m_valid;
   int          m_stalls;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   assign inst_data = mem(inst_addr);

   if_stage #(
      .RESET_PC   (32'h0000_0000),
      .BOOT_CYCLES(2),
      .NOP_INST   (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .inst_addr  (inst_addr),
      .inst_data  (inst_data),
      .ID_inst    (ID_inst),
      .ID_pc4     (ID_pc4),
      .ID_valid   (ID_valid),
      .stall_count(stall_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_boot_left = 2;
         m_pc        = 32'd0;
         m_inst      = 32'd0;
         m_pc4       = 32'd0;
         m_valid     = 1'b0;
         m_stalls    = 0;
      end else if (m_boot_left > 0) begin
         m_boot_left--;
      end else if (redirect_en) begin
         m_pc    = {redirect_pc[31:2], 2'b00};
         m_inst  = 32'd0;
         m_pc4   = 32'd0;
         m_valid = 1'b0;
      end else if (stall) begin
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_inst  = mem(m_pc);
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("inst_addr", inst_addr, m_pc);
         chk("ID_inst", ID_inst, m_inst);
         chk("ID_pc4", ID_pc4, m_pc4);
         chk("ID_valid", {31'd0, ID_valid}, {31'd0, m_valid});
         chk("stall_count", {16'd0, stall_count}, m_stalls);
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst = 1'b1;
      tick(2);
      chk("rst inst_addr", inst_addr, 32'h0);
      chk("rst ID_valid", {31'd0, ID_valid}, 32'd0);
      chk("rst ID_inst", ID_inst, 32'h0);
      chk("rst stall_count", {16'd0, stall_count}, 32'd0);
      cmp_en = 1'b1;
      rst = 1'b0;

      // Boot hold-off, then sequential fetch
      tick(1);
      chk("boot1 valid", {31'd0, ID_valid}, 32'd0);
      tick(1);
      chk("boot2 valid", {31'd0, ID_valid}, 32'd0);
      chk("boot2 addr", inst_addr, 32'h0);
      tick(1);
      chk("fetch0 inst", ID_inst, 32'h100);
      chk("fetch0 pc4", ID_pc4, 32'h4);
      tick(1);
      chk("fetch1 inst", ID_inst, 32'h104);
      chk("fetch1 pc4", ID_pc4, 32'h8);
      chk("fetch1 addr", inst_addr, 32'h8);
      tick(2);
      chk("pc at 0x10", inst_addr, 32'h10);

      // Stall for three edges
      stall = 1'b1;
      tick(3);
      chk("stall addr", inst_addr, 32'h10);
      chk("stall inst", ID_inst, 32'h10C);
      chk("stall count", {16'd0, stall_count}, 32'd3);
      stall = 1'b0;
      tick(1);
      chk("unstall inst", ID_inst, 32'h110);
      chk("unstall pc4", ID_pc4, 32'h14);
      tick(3);
      chk("pc at 0x20", inst_addr, 32'h20);

      // Redirect with misaligned target
      redirect_en = 1'b1;
      redirect_pc = 32'h0000_0403;
      tick(1);
      redirect_en = 1'b0;
      chk("redir addr", inst_addr, 32'h400);
      chk("redir valid", {31'd0, ID_valid}, 32'd0);
      chk("redir inst", ID_inst, 32'h0);
      tick(1);
      chk("redir fetch inst", ID_inst, 32'h500);
      chk("redir fetch pc4", ID_pc4, 32'h404);

      // Redirect beats stall
      stall = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h80;
      tick(1);
      stall = 1'b0;
      redirect_en = 1'b0;
      chk("rs addr", inst_addr, 32'h80);
      chk("rs valid", {31'd0, ID_valid}, 32'd0);
      chk("rs count", {16'd0, stall_count}, 32'd3);

      // Wrap at top of address space
      redirect_en = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick(1);
      redirect_en = 1'b0;
      tick(1);
      chk("wrap pc4", ID_pc4, 32'h0);
      chk("wrap addr", inst_addr, 32'h0);
      chk("wrap inst", ID_inst, 32'h0000_00FC);

      // Asynchronous reset between edges during a stall
      stall = 1'b1;
      tick(2);
      rst = 1'b1;
      #1;
      chk("arst addr", inst_addr, 32'h0);
      chk("arst valid", {31'd0, ID_valid}, 32'd0);
      chk("arst count", {16'd0, stall_count}, 32'd0);
      chk("arst pc4", ID_pc4, 32'h0);

      // Stall and redirect are ignored in BOOT
      redirect_en = 1'b1;
      redirect_pc = 32'h80;
      tick(1);
      rst = 1'b0;
      tick(2);
      chk("boot ign addr", inst_addr, 32'h0);
      chk("boot ign count", {16'd0, stall_count}, 32'd0);
      chk("boot ign valid", {31'd0, ID_valid}, 32'd0);
      stall = 1'b0;
      redirect_en = 1'b0;

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom_range(0, 99) < 30);
         redirect_en = ($urandom_range(0, 99) < 10);
         redirect_pc = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         tick(1);
      end

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
